// File: rtl/alarm_manager_pkg.sv
// clock_pkg: shared widths, slot record, reset alarm values and FSM encoding (SNOOZE only with ALARM_SNOOZE_EN)
package clock_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int NUM_ALARMS = 4;
  localparam int IDX_W = 2;
  localparam logic [HOUR_W-1:0] RST_HOUR0 = 5'd6;
  localparam logic [MIN_W-1:0] RST_MIN0 = 6'd0;
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0] min;
    logic en;
  } slot_t;
`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
`else
  typedef enum logic {IDLE, RING} state_t;
`endif
endpackage

// File: rtl/alarm_manager_if.sv
// alarm_manager_if: time, slot config, key and status bundle for alarm_manager
interface alarm_manager_if;
  import clock_pkg::*;
  logic tick_1hz;
  logic [HOUR_W-1:0] cur_hour, cfg_hour;
  logic [MIN_W-1:0] cur_min, cfg_min;
  logic [SEC_W-1:0] cur_sec;
  logic cfg_we, cfg_enable, key_off, key_snooze, beep, ringing;
  logic [IDX_W-1:0] cfg_idx, active_idx;
  logic [NUM_ALARMS-1:0] en_mask;
  modport master(
    output tick_1hz, cur_hour, cur_min, cur_sec, cfg_we, cfg_idx, cfg_hour, cfg_min, cfg_enable, key_off, key_snooze,
    input beep, ringing, active_idx, en_mask
  );
  modport slave(
    input tick_1hz, cur_hour, cur_min, cur_sec, cfg_we, cfg_idx, cfg_hour, cfg_min, cfg_enable, key_off, key_snooze,
    output beep, ringing, active_idx, en_mask
  );
endinterface

// File: rtl/alarm_manager_slot_bank.sv
// alarm_slot_bank: alarm slot registers, range-checked writes and lowest-index match encoder
module alarm_slot_bank
  import clock_pkg::*;
#(
  parameter int N = NUM_ALARMS
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [IDX_W-1:0] widx,
  input  logic [HOUR_W-1:0] whour,
  input  logic [MIN_W-1:0] wmin,
  input  logic wen,
  input  logic tick_d,
  input  logic [HOUR_W-1:0] hour,
  input  logic [MIN_W-1:0] min,
  input  logic [SEC_W-1:0] sec,
  output logic [N-1:0] en_mask,
  output logic wr_ok,
  output logic match_vld,
  output logic [IDX_W-1:0] match_idx
);
  slot_t slots [N];
  logic [N-1:0] hit;
  assign wr_ok = we && whour <= 5'd23 && wmin <= 6'd59;
  for (genvar g = 0; g < N; g++) begin : g_slot
    assign en_mask[g] = slots[g].en;
    assign hit[g] = tick_d && sec == '0 && slots[g].en && slots[g].hour == hour && slots[g].min == min;
  end
  // slot storage; an out-of-range write leaves every slot bit untouched
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < N; i++) slots[i] <= (i == 0) ? '{RST_HOUR0, RST_MIN0, 1'b1} : '0;
    else if (wr_ok)
      slots[widx] <= '{whour, wmin, wen};
  // lowest index wins when several slots match the same second
  always_comb begin
    match_vld = 1'b0;
    match_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (hit[i]) begin
        match_vld = 1'b1;
        match_idx = IDX_W'(i);
      end
  end
endmodule

// File: rtl/alarm_manager.sv
// alarm_manager: alarm ring/snooze FSM over the slot bank; define ALARM_SNOOZE_EN to build snooze support
module alarm_manager
  import clock_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input logic clk,
  input logic rst,
  alarm_manager_if.slave bus
);
  localparam int RW = $clog2(RING_SECS + 1);
  state_t state, state_nx;
  logic tick_d, match_vld, wr_ok, kill, stop;
  logic [IDX_W-1:0] match_idx, active_idx;
  logic [RW-1:0] ring_cnt;
  alarm_slot_bank #(.N(NUM_ALARMS)) u_bank (
    .clk(clk),
    .rst(rst),
    .we(bus.cfg_we),
    .widx(bus.cfg_idx),
    .whour(bus.cfg_hour),
    .wmin(bus.cfg_min),
    .wen(bus.cfg_enable),
    .tick_d(tick_d),
    .hour(bus.cur_hour),
    .min(bus.cur_min),
    .sec(bus.cur_sec),
    .en_mask(bus.en_mask),
    .wr_ok(wr_ok),
    .match_vld(match_vld),
    .match_idx(match_idx)
  );
  assign kill = wr_ok && bus.cfg_idx == active_idx && !bus.cfg_enable;
  assign stop = bus.key_off || kill;
`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
  localparam int CW = $clog2(MAX_SNOOZE + 1);
  logic [SW-1:0] snz_timer;
  logic [CW-1:0] snooze_cnt;
  logic snz_go;
  assign snz_go = bus.key_snooze && snooze_cnt < CW'(MAX_SNOOZE);
  // snooze countdown and per-event snooze tally
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      snz_timer <= '0;
      snooze_cnt <= '0;
    end else if (state == IDLE && match_vld)
      snooze_cnt <= '0;
    else if (state == RING && state_nx == SNOOZE) begin
      snz_timer <= SW'(SNOOZE_MIN * 60);
      snooze_cnt <= snooze_cnt + 1'b1;
    end else if (state == SNOOZE && bus.tick_1hz && snz_timer != '0)
      snz_timer <= snz_timer - 1'b1;
`else
  logic unused_snooze;
  assign unused_snooze = &{bus.key_snooze, SNOOZE_MIN[0], MAX_SNOOZE[0]};
`endif
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next state; key_off and an enable-clearing write of the active slot beat everything else
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = match_vld ? RING : IDLE;
`ifdef ALARM_SNOOZE_EN
      RING: state_nx = (stop || ring_cnt == '0) ? IDLE : snz_go ? SNOOZE : RING;
      SNOOZE: state_nx = stop ? IDLE : snz_timer == '0 ? RING : SNOOZE;
`else
      RING: state_nx = (stop || ring_cnt == '0) ? IDLE : RING;
`endif
      default: state_nx = IDLE;
    endcase
  end
  // tick delay, event slot latch and ring countdown (reloaded on every entry to RING)
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tick_d <= 1'b0;
      active_idx <= '0;
      ring_cnt <= '0;
    end else begin
      tick_d <= bus.tick_1hz;
      if (state == IDLE && match_vld) active_idx <= match_idx;
      if (state_nx == RING && state != RING) ring_cnt <= RW'(RING_SECS);
      else if (state == RING && bus.tick_1hz && ring_cnt != '0) ring_cnt <= ring_cnt - 1'b1;
    end
  // outputs decode from state alone so reset silences the buzzer immediately
  always_comb begin
    bus.beep = state == RING;
    bus.ringing = state != IDLE;
    bus.active_idx = active_idx;
  end
endmodule

// File: tb/tb_alarm_manager.sv
// tb_alarm_manager: directed vector table plus hand sequences for ring, snooze, kill and reset
module tb_alarm_manager;
  import clock_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  alarm_manager_if bus();
  alarm_manager dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #10 clk = ~clk;

  typedef struct {
    logic we;
    logic [1:0] idx;
    logic [4:0] h;
    logic [5:0] m;
    logic en;
    logic tk;
    logic [4:0] th;
    logic [5:0] tm;
    logic [5:0] ts;
    logic [3:0] mask;
    logic ring;
    logic [1:0] aidx;
  } vec_t;
  vec_t vt[12];

  function automatic vec_t mk(input int we, idx, h, m, en, tk, th, tm, ts, mask, ring, aidx);
    vec_t v;
    v.we = we[0]; v.idx = idx[1:0]; v.h = h[4:0]; v.m = m[5:0]; v.en = en[0];
    v.tk = tk[0]; v.th = th[4:0]; v.tm = tm[5:0]; v.ts = ts[5:0];
    v.mask = mask[3:0]; v.ring = ring[0]; v.aidx = aidx[1:0];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int h, m, s);
    bus.cur_hour = h[4:0];
    bus.cur_min = m[5:0];
    bus.cur_sec = s[5:0];
  endtask

  task automatic pulse(input int h, m, s);
    bus.tick_1hz = 1'b1;
    cyc(1);
    bus.tick_1hz = 1'b0;
    set_time(h, m, s);
  endtask

  task automatic wr(input int idx, h, m, en);
    bus.cfg_we = 1'b1;
    bus.cfg_idx = idx[1:0];
    bus.cfg_hour = h[4:0];
    bus.cfg_min = m[5:0];
    bus.cfg_enable = en[0];
    cyc(1);
    bus.cfg_we = 1'b0;
  endtask

  task automatic key(input logic off, snz);
    bus.key_off = off;
    bus.key_snooze = snz;
    cyc(1);
    bus.key_off = 1'b0;
    bus.key_snooze = 1'b0;
  endtask

  task automatic ring2();
    set_time(7, 29, 59);
    pulse(7, 30, 0);
    cyc(1);
  endtask

  initial begin
    bus.tick_1hz = 0; bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_hour = 0; bus.cfg_min = 0;
    bus.cfg_enable = 0; bus.key_off = 0; bus.key_snooze = 0;
    set_time(0, 0, 1);
    vt[0]  = mk(0, 0,  0,  0, 0, 1,  6,  0, 0, 4'b0001, 1, 0);
    vt[1]  = mk(1, 0, 24,  0, 0, 1,  6,  0, 0, 4'b0001, 1, 0);
    vt[2]  = mk(1, 0,  6, 60, 0, 1,  6,  0, 0, 4'b0001, 1, 0);
    vt[3]  = mk(1, 2,  7, 30, 1, 1,  7, 30, 0, 4'b0101, 1, 2);
    vt[4]  = mk(0, 0,  0,  0, 0, 1,  7, 30, 1, 4'b0101, 0, 0);
    vt[5]  = mk(0, 0,  0,  0, 0, 1,  7, 31, 0, 4'b0101, 0, 0);
    vt[6]  = mk(1, 1,  8,  0, 1, 0,  0,  0, 0, 4'b0111, 0, 0);
    vt[7]  = mk(1, 3,  8,  0, 1, 1,  8,  0, 0, 4'b1111, 1, 1);
    vt[8]  = mk(1, 1,  8,  0, 0, 1,  8,  0, 0, 4'b1101, 1, 3);
    vt[9]  = mk(1, 3, 23, 59, 1, 1, 23, 59, 0, 4'b1101, 1, 3);
    vt[10] = mk(1, 0,  6,  0, 0, 1,  6,  0, 0, 4'b1100, 0, 0);
    vt[11] = mk(1, 2,  0,  0, 0, 1,  7, 30, 0, 4'b1000, 0, 0);
    cyc(2);
    chk("rst_beep", bus.beep, 0);
    chk("rst_ringing", bus.ringing, 0);
    chk("rst_active_idx", bus.active_idx, 0);
    chk("rst_en_mask", bus.en_mask, 4'b0001);
    rst = 1'b1;
    cyc(2);
    for (int i = 0; i < 12; i++) begin
      if (vt[i].we) wr(vt[i].idx, vt[i].h, vt[i].m, vt[i].en);
      if (vt[i].tk) begin
        pulse(vt[i].th, vt[i].tm, vt[i].ts);
        cyc(1);
      end
      chk($sformatf("v%0d_en_mask", i), bus.en_mask, vt[i].mask);
      chk($sformatf("v%0d_ringing", i), bus.ringing, vt[i].ring);
      chk($sformatf("v%0d_beep", i), bus.beep, vt[i].ring);
      if (vt[i].ring) chk($sformatf("v%0d_active_idx", i), bus.active_idx, vt[i].aidx);
      key(1'b1, 1'b0);
      chk($sformatf("v%0d_after_off", i), bus.ringing, 0);
    end
    wr(2, 7, 30, 1);
    set_time(7, 29, 59);
    pulse(7, 30, 0);
    chk("match_beep_t1", bus.beep, 0);
    cyc(1);
    chk("match_beep_t2", bus.beep, 1);
    chk("match_active_idx", bus.active_idx, 2);
    repeat (59) begin
      pulse(7, 30, 1);
      cyc(1);
    end
    chk("ring_tick59_beep", bus.beep, 1);
    pulse(7, 30, 1);
    cyc(1);
    chk("ring_tick60_beep", bus.beep, 0);
    chk("ring_tick60_ringing", bus.ringing, 0);
    ring2();
`ifdef ALARM_SNOOZE_EN
    for (int k = 0; k < 4; k++) begin
      key(1'b0, 1'b1);
      if (k < 3) begin
        chk($sformatf("snz%0d_beep", k), bus.beep, 0);
        chk($sformatf("snz%0d_ringing", k), bus.ringing, 1);
        repeat (300) begin
          pulse(7, 30, 1);
          cyc(1);
        end
        chk($sformatf("snz%0d_rering", k), bus.beep, 1);
        chk($sformatf("snz%0d_active_idx", k), bus.active_idx, 2);
      end else begin
        chk("snz_limit_beep", bus.beep, 1);
      end
    end
`else
    key(1'b0, 1'b1);
    chk("snz_ignored_beep", bus.beep, 1);
    chk("snz_ignored_ringing", bus.ringing, 1);
`endif
    cyc(1);
    chk("snz_hold_beep", bus.beep, 1);
    key(1'b1, 1'b0);
    ring2();
    chk("both_pre_beep", bus.beep, 1);
    key(1'b1, 1'b1);
    chk("both_keys_beep", bus.beep, 0);
    chk("both_keys_ringing", bus.ringing, 0);
    ring2();
    wr(1, 8, 0, 1);
    chk("other_write_ringing", bus.ringing, 1);
    wr(2, 7, 30, 0);
    chk("kill_ringing", bus.ringing, 0);
    chk("kill_en_mask", bus.en_mask, 4'b1010);
    wr(2, 7, 30, 1);
    ring2();
    wr(0, 9, 15, 0);
    chk("pre_rst_beep", bus.beep, 1);
    #5 rst = 1'b0;
    #1;
    chk("async_rst_beep", bus.beep, 0);
    chk("async_rst_ringing", bus.ringing, 0);
    chk("async_rst_en_mask", bus.en_mask, 4'b0001);
    chk("async_rst_active_idx", bus.active_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    chk("post_rst_beep", bus.beep, 0);
    set_time(5, 59, 59);
    pulse(6, 0, 0);
    cyc(1);
    chk("post_rst_slot0_ring", bus.ringing, 1);
    chk("post_rst_slot0_idx", bus.active_idx, 0);
    key(1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
